// File: rtl/rotary_decoder.sv
// -----------------------------------------------------------------------------
// rotary_decoder
//
// Quadrature decoder for the front-panel rotary encoder. It sits behind the
// debouncers that clean the A/B contacts. It follows the Gray-code phase {a,b}
// and emits one step pulse per detent, together with the direction. It also
// keeps a signed detent position and counts illegal (double-bit) transitions
// for diagnostics.
//
// Parameters
//   POS_WIDTH         width of the signed position output (2..32)
//   STEPS_PER_DETENT  quadrature transitions per reported step (1, 2 or 4)
//   WRAP              0 = position saturates, 1 = two's-complement wrap
//
// Ports
//   aclk       in   system clock, rising edge
//   aresetn    in   asynchronous active-low reset
//   a, b       in   debounced encoder channels, synchronous to aclk
//   clear      in   synchronous clear of position, sub-step and err_count
//   step       out  one-cycle pulse per detent
//   dir        out  direction of the last step (1 = CW, 0 = CCW), held
//   position   out  signed detent count
//   error      out  one-cycle pulse on an illegal transition
//   err_count  out  illegal-transition count, saturating at 255
// -----------------------------------------------------------------------------
module rotary_decoder #(
  parameter int POS_WIDTH        = 16,
  parameter int STEPS_PER_DETENT = 4,
  parameter int WRAP             = 0
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        a,
  input  logic                        b,
  input  logic                        clear,
  output logic                        step,
  output logic                        dir,
  output logic signed [POS_WIDTH-1:0] position,
  output logic                        error,
  output logic [7:0]                  err_count
);

  // Transition class. The encoding equals the modulo-4 difference of the
  // binary phase indices, so the class is a direct cast of that difference.
  typedef enum logic [1:0] {
    MV_SAME    = 2'd0,
    MV_CW      = 2'd1,
    MV_ILLEGAL = 2'd2,
    MV_CCW     = 2'd3
  } move_e;

  localparam logic signed [POS_WIDTH-1:0] POS_MAX  = {1'b0, {(POS_WIDTH-1){1'b1}}};
  localparam logic signed [POS_WIDTH-1:0] POS_MIN  = {1'b1, {(POS_WIDTH-1){1'b0}}};
  localparam logic signed [POS_WIDTH-1:0] POS_ONE  = {{(POS_WIDTH-1){1'b0}}, 1'b1};
  localparam logic signed [POS_WIDTH-1:0] POS_ZERO = '0;
  localparam logic signed [3:0]           SUB_ONE  = 4'sd1;
  localparam logic signed [3:0]           SUB_TGT  = 4'(STEPS_PER_DETENT);

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Gray phase to binary index along the CW sequence 00,01,11,10.
  function automatic logic [1:0] phase_idx(input logic [1:0] ph);
    return {ph[1], ph[1] ^ ph[0]};
  endfunction

  // One detent forward, saturating or wrapping at the positive limit.
  function automatic logic signed [POS_WIDTH-1:0] pos_inc(
    input logic signed [POS_WIDTH-1:0] p
  );
    if (WRAP == 0 && p == POS_MAX) return POS_MAX;
    return p + POS_ONE;
  endfunction

  // One detent backward, saturating or wrapping at the negative limit.
  function automatic logic signed [POS_WIDTH-1:0] pos_dec(
    input logic signed [POS_WIDTH-1:0] p
  );
    if (WRAP == 0 && p == POS_MIN) return POS_MIN;
    return p - POS_ONE;
  endfunction

  // 8-bit saturating increment for the diagnostics counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) return 8'hFF;
    return v + 8'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]                  cur_q, cur_d;
  logic [1:0]                  prev_q, prev_d;
  logic                        primed_q, primed_d;
  logic signed [3:0]           sub_q, sub_d;
  logic                        step_q, step_d;
  logic                        dir_q, dir_d;
  logic signed [POS_WIDTH-1:0] pos_q, pos_d;
  logic                        error_q, error_d;
  logic [7:0]                  err_cnt_q, err_cnt_d;

  move_e                       move;
  logic signed [3:0]           sub_up;
  logic signed [3:0]           sub_dn;

  assign move   = move_e'(phase_idx(cur_q) - phase_idx(prev_q));
  assign sub_up = sub_q + SUB_ONE;
  assign sub_dn = sub_q - SUB_ONE;

  // ---------------------------------------------------------------------------
  // Next-state logic: classify cur vs prev and update the counters
  // ---------------------------------------------------------------------------
  always_comb begin
    cur_d     = {a, b};
    // Until primed, prev is loaded with the same sample as cur so that the
    // first comparison is always "same" and power-up state never counts.
    prev_d    = primed_q ? cur_q : {a, b};
    primed_d  = 1'b1;
    sub_d     = sub_q;
    step_d    = 1'b0;
    dir_d     = dir_q;
    pos_d     = pos_q;
    error_d   = 1'b0;
    err_cnt_d = err_cnt_q;

    if (primed_q) begin
      unique case (move)
        MV_SAME: ;
        MV_CW: begin
          if (sub_up == SUB_TGT) begin
            step_d = 1'b1;
            dir_d  = 1'b1;
            pos_d  = pos_inc(pos_q);
            sub_d  = '0;
          end else begin
            sub_d  = sub_up;
          end
        end
        MV_CCW: begin
          if (sub_dn == -SUB_TGT) begin
            step_d = 1'b1;
            dir_d  = 1'b0;
            pos_d  = pos_dec(pos_q);
            sub_d  = '0;
          end else begin
            sub_d  = sub_dn;
          end
        end
        MV_ILLEGAL: begin
          error_d   = 1'b1;
          err_cnt_d = sat_inc8(err_cnt_q);
          sub_d     = '0;
        end
      endcase
    end

    // Clear wins; the transition evaluated this cycle is consumed and lost
    // because prev still advances above.
    if (clear) begin
      pos_d     = POS_ZERO;
      sub_d     = '0;
      err_cnt_d = '0;
      step_d    = 1'b0;
      error_d   = 1'b0;
      dir_d     = dir_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cur_q     <= 2'b00;
      prev_q    <= 2'b00;
      primed_q  <= 1'b0;
      sub_q     <= '0;
      step_q    <= 1'b0;
      dir_q     <= 1'b0;
      pos_q     <= POS_ZERO;
      error_q   <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      cur_q     <= cur_d;
      prev_q    <= prev_d;
      primed_q  <= primed_d;
      sub_q     <= sub_d;
      step_q    <= step_d;
      dir_q     <= dir_d;
      pos_q     <= pos_d;
      error_q   <= error_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign step      = step_q;
  assign dir       = dir_q;
  assign position  = pos_q;
  assign error     = error_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_rotary_decoder.sv
// -----------------------------------------------------------------------------
// tb_rotary_decoder
//
// Drives several rotary_decoder configurations from one shared A/B/clear/reset
// stimulus. A behavioural model tracks each configuration from the sampled
// phase history and is compared against every DUT output each cycle; a few
// scenario-level checks compare against hand-derived constants.
// -----------------------------------------------------------------------------
module tb_rotary_decoder;

  localparam int NI = 5;

  function automatic int pw_of(input int i);
    case (i)
      0:       return 16;
      1:       return 4;
      2:       return 4;
      3:       return 8;
      default: return 6;
    endcase
  endfunction

  function automatic int spd_of(input int i);
    case (i)
      3:       return 1;
      4:       return 2;
      default: return 4;
    endcase
  endfunction

  function automatic int wrap_of(input int i);
    case (i)
      2:       return 1;
      4:       return 1;
      default: return 0;
    endcase
  endfunction

  logic aclk;
  logic aresetn;
  logic a;
  logic b;
  logic clear;

  logic        step_w  [NI];
  logic        dir_w   [NI];
  logic        error_w [NI];
  logic [7:0]  err_w   [NI];
  logic [63:0] pos_w   [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int PW = pw_of(g);
    logic [PW-1:0] pos_l;
    rotary_decoder #(
      .POS_WIDTH       (PW),
      .STEPS_PER_DETENT(spd_of(g)),
      .WRAP            (wrap_of(g))
    ) u_dut (
      .aclk     (aclk),
      .aresetn  (aresetn),
      .a        (a),
      .b        (b),
      .clear    (clear),
      .step     (step_w[g]),
      .dir      (dir_w[g]),
      .position (pos_l),
      .error    (error_w[g]),
      .err_count(err_w[g])
    );
    assign pos_w[g] = {{(64-PW){pos_l[PW-1]}}, pos_l};
  end

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: works on the sequence of sampled phases
  // ---------------------------------------------------------------------------
  int     m_n    [NI];   // samples taken since reset (capped at 2)
  int     m_prev [NI];
  int     m_cur  [NI];
  int     m_sub  [NI];
  int     m_dir  [NI];
  int     m_step [NI];
  int     m_err  [NI];
  int     m_ec   [NI];
  longint m_pos  [NI];
  int     cnt_step [NI];

  function automatic int cw_next(input int ph);
    case (ph)
      0:       return 1;
      1:       return 3;
      3:       return 2;
      default: return 0;
    endcase
  endfunction

  function automatic int ccw_next(input int ph);
    case (ph)
      0:       return 2;
      2:       return 3;
      3:       return 1;
      default: return 0;
    endcase
  endfunction

  function automatic longint pos_move(input int i, input longint p, input int d);
    longint mx, mn, np;
    mx = (64'sd1 <<< (pw_of(i) - 1)) - 1;
    mn = -(64'sd1 <<< (pw_of(i) - 1));
    np = p + d;
    if (np > mx) np = (wrap_of(i) != 0) ? mn : mx;
    if (np < mn) np = (wrap_of(i) != 0) ? mx : mn;
    return np;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_n[i] = 0;  m_prev[i] = 0; m_cur[i] = 0; m_sub[i] = 0;
      m_dir[i] = 0; m_step[i] = 0; m_err[i] = 0; m_ec[i] = 0;
      m_pos[i] = 0;
    end
  endtask

  task automatic model_edge(input int ab, input bit clr);
    for (int i = 0; i < NI; i++) begin
      int d;
      bit ill;
      d = 0;
      ill = 1'b0;
      m_step[i] = 0;
      m_err[i]  = 0;
      if (m_n[i] >= 2 && m_cur[i] != m_prev[i]) begin
        if (m_cur[i] == cw_next(m_prev[i]))       d = 1;
        else if (m_prev[i] == cw_next(m_cur[i]))  d = -1;
        else                                      ill = 1'b1;
      end
      if (clr) begin
        m_pos[i] = 0;
        m_sub[i] = 0;
        m_ec[i]  = 0;
      end else if (ill) begin
        m_err[i] = 1;
        m_ec[i]  = (m_ec[i] < 255) ? m_ec[i] + 1 : 255;
        m_sub[i] = 0;
      end else if (d != 0) begin
        m_sub[i] += d;
        if (m_sub[i] == spd_of(i) || m_sub[i] == -spd_of(i)) begin
          m_step[i] = 1;
          m_dir[i]  = (d > 0) ? 1 : 0;
          m_pos[i]  = pos_move(i, m_pos[i], d);
          m_sub[i]  = 0;
        end
      end
      m_prev[i] = m_cur[i];
      m_cur[i]  = ab;
      if (m_n[i] < 2) m_n[i]++;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("u%0d_step", i), longint'(step_w[i]), m_step[i]);
      check_eq($sformatf("u%0d_error", i), longint'(error_w[i]), m_err[i]);
      check_eq($sformatf("u%0d_dir", i), longint'(dir_w[i]), m_dir[i]);
      check_eq($sformatf("u%0d_position", i), longint'($signed(pos_w[i])), m_pos[i]);
      check_eq($sformatf("u%0d_err_count", i), longint'(err_w[i]), m_ec[i]);
      if (step_w[i] === 1'b1) cnt_step[i]++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  int cur_ph = 3;

  task automatic cyc(input int ab, input bit clr);
    a     = ab[1];
    b     = ab[0];
    clear = clr;
    @(posedge aclk);
    if (aresetn) model_edge(ab, clr);
    #1;
    check_all();
  endtask

  task automatic hold(input int ab, input int n);
    cur_ph = ab;
    repeat (n) cyc(ab, 1'b0);
  endtask

  task automatic detents(input int cnt, input bit cw, input int h);
    for (int k = 0; k < cnt; k++)
      for (int q = 0; q < 4; q++)
        hold(cw ? cw_next(cur_ph) : ccw_next(cur_ph), h);
  endtask

  // Asserts reset asynchronously between edges, holds it, then releases it
  // on a falling edge.
  task automatic do_reset(input int ab, input int n);
    a = ab[1];
    b = ab[0];
    clear = 1'b0;
    cur_ph = ab;
    #2 aresetn = 1'b0;
    model_reset();
    #1 check_all();
    repeat (n) cyc(ab, 1'b0);
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int s0;
    for (int i = 0; i < NI; i++) cnt_step[i] = 0;
    aresetn = 1'b0;
    a = 1'b1;
    b = 1'b1;
    clear = 1'b0;
    model_reset();
    repeat (3) @(posedge aclk);
    #1 check_all();
    @(negedge aclk);
    aresetn = 1'b1;

    // Power-up with {a,b}=11 held: priming only, nothing reported.
    hold(3, 8);
    check_eq("prime_position", longint'($signed(pos_w[0])), 0);
    check_eq("prime_steps", cnt_step[0], 0);
    check_eq("prime_errors", longint'(err_w[0]), 0);

    // Walk to 00 and clear the partial progress.
    hold(2, 8);
    hold(0, 8);
    cyc(0, 1'b1);
    hold(0, 2);

    // Three CW detents, then two CCW.
    s0 = cnt_step[0];
    detents(3, 1'b1, 8);
    check_eq("cw3_position", longint'($signed(pos_w[0])), 3);
    check_eq("cw3_dir", longint'(dir_w[0]), 1);
    check_eq("cw3_steps", cnt_step[0] - s0, 3);
    detents(2, 1'b0, 8);
    check_eq("ccw2_position", longint'($signed(pos_w[0])), 1);
    check_eq("ccw2_dir", longint'(dir_w[0]), 0);

    // Partial rotation then reversal: no step.
    s0 = cnt_step[0];
    hold(1, 8); hold(3, 8); hold(1, 8); hold(0, 8);
    check_eq("partial_steps", cnt_step[0] - s0, 0);
    check_eq("partial_position", longint'($signed(pos_w[0])), 1);

    // Single illegal transition, then 300 more.
    s0 = cnt_step[0];
    hold(3, 8);
    check_eq("ill1_err_count", longint'(err_w[0]), 1);
    check_eq("ill1_steps", cnt_step[0] - s0, 0);
    for (int k = 0; k < 300; k++) hold((k % 2 == 0) ? 0 : 3, 1);
    hold(0, 4);
    check_eq("ill300_err_count", longint'(err_w[0]), 255);

    // Narrow positions: wrap instance reaches -8 after 8 detents, saturating
    // instance stops at 7 after 10.
    cyc(0, 1'b1);
    hold(0, 2);
    s0 = cnt_step[1];
    detents(8, 1'b1, 2);
    check_eq("wrap8_position", longint'($signed(pos_w[2])), -8);
    detents(2, 1'b1, 2);
    check_eq("sat10_position", longint'($signed(pos_w[1])), 7);
    check_eq("sat10_steps", cnt_step[1] - s0, 10);

    // Clear coincident with detent completion.
    hold(1, 4); hold(3, 4); hold(2, 4);
    cyc(0, 1'b0);
    cyc(0, 1'b1);
    check_eq("clr_step", longint'(step_w[0]), 0);
    check_eq("clr_position", longint'($signed(pos_w[0])), 0);
    hold(0, 3);

    // Reset mid-detent, then finish the detent: nothing reported.
    s0 = cnt_step[0];
    hold(1, 4); hold(3, 4);
    do_reset(3, 3);
    hold(3, 4); hold(2, 4); hold(0, 4);
    check_eq("rst_mid_steps", cnt_step[0] - s0, 0);

    // Back-to-back transitions, one per cycle.
    detents(5, 1'b1, 1);
    detents(3, 1'b0, 1);

    // Randomized walk with occasional clear and reset.
    for (int k = 0; k < 1500; k++) begin
      int r, h, nx;
      r = $urandom_range(0, 99);
      h = $urandom_range(1, 3);
      if (r < 40)      nx = cw_next(cur_ph);
      else if (r < 80) nx = ccw_next(cur_ph);
      else if (r < 88) nx = cur_ph ^ 3;
      else             nx = cur_ph;
      if ($urandom_range(0, 199) == 0) begin
        do_reset(nx, 2);
      end else if ($urandom_range(0, 49) == 0) begin
        cur_ph = nx;
        cyc(nx, 1'b1);
      end else begin
        hold(nx, h);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rotary_decoder.md
# rotary_decoder

Quadrature decoder for the front-panel rotary encoder. It sits directly downstream of the two `debounce` instances that clean the encoder's A and B contacts. It tracks the Gray-code phase of the debounced A/B pair and emits one step pulse with direction per detent. It also maintains a signed position count and flags illegal (double-bit) transitions for diagnostics.

## Interface
- `POS_WIDTH`, 16: width of the signed `position` output; legal range 2..32.
- `STEPS_PER_DETENT`, 4: quadrature transitions per reported step; legal values 1, 2, 4.
- `WRAP`, 0: 0 = `position` saturates at its signed limits; 1 = two's-complement wrap-around.
- `aclk` input 1: system clock; all logic is on the rising edge.
- `aresetn` input 1: asynchronous active-low reset.
- `a` input 1: debounced encoder channel A, synchronous to `aclk`.
- `b` input 1: debounced encoder channel B, synchronous to `aclk`.
- `clear` input 1: synchronous clear of `position`, the sub-step accumulator and `err_count`.
- `step` output 1: one-cycle pulse, one per detent.
- `dir` output 1: direction of the most recent step; 1 = CW, 0 = CCW. Held between steps.
- `position` output POS_WIDTH: signed detent count.
- `error` output 1: one-cycle pulse on an illegal transition.
- `err_count` output 8: illegal-transition count, saturating at 255.

## Operation
- Phase is the 2-bit value `{a,b}`. The CW sequence is 00→01→11→10→00; CCW is the reverse.
- Input register `cur` samples `{a,b}` every cycle. `prev` holds the previous `cur`.
- A `primed` flag is cleared by reset and set on the first cycle after reset. While `primed`=0, `prev` loads `cur` and no transition is evaluated, so power-up state never counts.
- Each cycle with `primed`=1, `cur` is compared with `prev` and classified:
  - **same**: no action.
  - **+1**: CW neighbour.
  - **−1**: CCW neighbour.
  - **illegal**: both bits differ.
- Sub-step accumulator `sub` is signed, 4 bits, reset 0.
  - +1 increments `sub`; −1 decrements it.
  - A reversal mid-detent therefore cancels the partial progress and never emits a step.
- Step rule:
  - When `sub` would reach +STEPS_PER_DETENT: `step`=1, `dir`=1, `position`+1, `sub`←0.
  - When it would reach −STEPS_PER_DETENT: `step`=1, `dir`=0, `position`−1, `sub`←0.
- Illegal rule: `error`=1, `err_count`+1 (saturating at 255), `sub`←0, `position` unchanged, `dir` unchanged.
- `prev` ← `cur` every cycle, including on illegal transitions.
- Position limits:
  - WRAP=0: clamps at 2^(POS_WIDTH−1)−1 and −2^(POS_WIDTH−1). `step` and `dir` still pulse/update at the limit.
  - WRAP=1: max+1 → min and min−1 → max.
- `clear`=1 has priority in that cycle:
  - `position`←0, `sub`←0, `err_count`←0.
  - `step` and `error` are forced 0; `dir` holds.
  - `prev` still updates, so a transition coincident with `clear` is consumed and lost.

## Timing
- Reset values: `step`=0, `dir`=0, `position`=0, `error`=0, `err_count`=0, `sub`=0, `primed`=0, `cur`=`prev`=00.
- Reset assertion clears all state immediately. Deassertion is sampled on `aclk`; the first `cur` sample after deassertion only primes.
- Latency: an `a`/`b` change sampled into `cur` at edge k produces `step`/`error`, and the updated `position`/`dir`/`err_count`, registered at edge k+1.
- `step` and `error` are high for exactly one cycle per event; they are never asserted together.
- Throughput: one transition per cycle is accepted. Back-to-back steps at STEPS_PER_DETENT=1 yield `step` high on consecutive cycles.
- `position` and `dir` change only in the cycle `step` rises, or on `clear`.
- `clear` takes effect at the edge it is sampled: outputs show zero from edge+1.
- Reset asserted mid-detent discards `sub`. Partial rotation before reset is never reported.

## Test plan
- Reset held low with `{a,b}`=11, then released and held → `primed` set, no `step`/`error`, `position`=0.
- STEPS_PER_DETENT=4, drive 00→01→11→10→00 three times, 8 cycles per phase → three `step` pulses, `dir`=1, `position`=3. Then the reverse sequence twice → `position`=1, `dir`=0.
- Drive 00→01→11→01→00 (partial then reverse) → no `step`, `position` unchanged, `sub` back to 0.
- Drive 00→11 → one `error` pulse, `err_count`=1, no `step`. Drive 300 illegal transitions → `err_count`=255.
- POS_WIDTH=4:
  - WRAP=0: 10 CW detents → `position`=7 with 10 `step` pulses.
  - WRAP=1: 8 CW detents from 0 → `position`=−8.
- Assert `clear` in the same cycle a detent completes → `step`=0, `position`=0 next cycle. Assert `aresetn` low mid-detent, then complete the detent → no `step`.
